// File: rtl/duty_ramp_pkg.sv
// Shared types and constants for the duty_ramp slew-rate limiter.
package duty_ramp_pkg;

    localparam int DUTY_W    = 8;
    localparam int FRAME_LEN = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/duty_ramp_if.sv
// Target handshake between the duty requester (master) and duty_ramp (slave).
interface duty_ramp_if;
    import duty_ramp_pkg::*;

    logic [DUTY_W-1:0] tgt_duty;
    logic              tgt_vld;
    logic              tgt_rdy;

    modport master (output tgt_duty, output tgt_vld, input tgt_rdy);
    modport slave  (input tgt_duty, input tgt_vld, output tgt_rdy);

endinterface

// File: rtl/duty_ramp_frame_timer.sv
// PWM frame counter plus a frame divider that flags when a duty step is due.
module frame_timer
    import duty_ramp_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dcnt_clr,
    output logic frame_tick,
    output logic step_due
);

    localparam int FCNT_W = $clog2(FRAME_LEN);
    localparam int DCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DIV - 1);

    logic [FCNT_W-1:0] fcnt;
    logic [DCNT_W-1:0] dcnt;

    // Free-running; reset together with the PWM so both frames stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= '0;
        end else if (dcnt_clr) begin
            dcnt <= '0;
        end else if (frame_tick) begin
            dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + DCNT_W'(1);
        end
    end

    assign frame_tick = (fcnt == FCNT_LAST);
    assign step_due   = frame_tick && (dcnt == DCNT_LAST);

endmodule

// File: rtl/duty_ramp.sv
// Slew-rate limiter walking the PWM duty toward a handshaken target.
// Define DUTY_RAMP_CLAMP_EN to cap accepted targets at MAX_DUTY.
module duty_ramp
    import duty_ramp_pkg::*;
#(
    parameter int                STEP     = 1,
    parameter int                DIV      = 4,
    parameter logic [DUTY_W-1:0] MAX_DUTY = 8'hF0
) (
    input  logic              clk,
    input  logic              rst_n,
    duty_ramp_if.slave        tgt,
    output logic [DUTY_W-1:0] duty,
    output logic              at_tgt,
    output logic              frame_tick
);

`ifdef DUTY_RAMP_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic [DUTY_W:0] STEP_X = STEP[DUTY_W:0];

    ramp_state_t       state, state_nx;
    logic [DUTY_W-1:0] tgt_q;
    logic [DUTY_W-1:0] acc_duty;
    logic [DUTY_W-1:0] next_duty;
    logic              rdy;
    logic              accept;
    logic              step_due;

    function automatic logic [DUTY_W-1:0] clamp_tgt(input logic [DUTY_W-1:0] t);
        return (CLAMP_EN && (t > MAX_DUTY)) ? MAX_DUTY : t;
    endfunction

    // Extra carry bit keeps duty from wrapping past full scale.
    function automatic logic [DUTY_W-1:0] sat_up(input logic [DUTY_W-1:0] d,
                                                 input logic [DUTY_W-1:0] t);
        logic [DUTY_W:0] sum;
        sum = {1'b0, d} + STEP_X;
        return (sum >= {1'b0, t}) ? t : sum[DUTY_W-1:0];
    endfunction

    // Borrow bit set means the subtraction went below zero.
    function automatic logic [DUTY_W-1:0] sat_down(input logic [DUTY_W-1:0] d,
                                                   input logic [DUTY_W-1:0] t);
        logic [DUTY_W:0] diff;
        diff = {1'b0, d} - STEP_X;
        return (diff[DUTY_W] || (diff[DUTY_W-1:0] <= t)) ? t : diff[DUTY_W-1:0];
    endfunction

    frame_timer #(.DIV(DIV)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .dcnt_clr   (accept),
        .frame_tick (frame_tick),
        .step_due   (step_due)
    );

    assign acc_duty    = clamp_tgt(tgt.tgt_duty);
    assign accept      = tgt.tgt_vld && rdy;
    assign tgt.tgt_rdy = rdy;

    always_comb begin
        next_duty = duty;
        case (state)
            UP:      next_duty = sat_up(duty, tgt_q);
            DOWN:    next_duty = sat_down(duty, tgt_q);
            default: next_duty = duty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (acc_duty > duty) begin
                        state_nx = UP;
                    end else if (acc_duty < duty) begin
                        state_nx = DOWN;
                    end
                end
            end
            UP, DOWN: begin
                if (step_due && (next_duty == tgt_q)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rdy    = (state == IDLE);
        at_tgt = (state == IDLE);
    end

    // Duty moves only on the last clock of a frame, so the PWM never sees a mid-period change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q <= '0;
            duty  <= '0;
        end else begin
            if (accept) begin
                tgt_q <= acc_duty;
            end
            if (step_due && (state != IDLE)) begin
                duty <= next_duty;
            end
        end
    end

endmodule
